// File: rtl/tdm_demux_1xn.sv
// -----------------------------------------------------------------------------
// tdm_demux_1xn
//
// Receive end of a time-division-multiplexed link. The upstream mux sends one
// W-bit sample per beat and cycles through N slots, with frame_sync marking
// slot 0. This block locks to frame_sync and tracks the slot position. It
// collects the N samples of a frame and presents them together as one
// parallel word, with a single-cycle valid strobe. It also flags framing
// errors.
//
// Parameters
//   N  channels (slots) per frame, legal range 2..16
//   W  bits per sample
//
// Ports
//   clk         in   1    single clock, rising edge
//   rst         in   1    synchronous, active-high reset
//   din         in   W    TDM sample for the current slot
//   din_valid   in   1    din carries a beat this cycle; gaps are allowed
//   frame_sync  in   1    marks the beat as slot 0; ignored when din_valid=0
//   dout        out  N*W  last complete frame, channel k at dout[k*W +: W]
//   dout_valid  out  1    one-cycle strobe: dout was just updated
//   locked      out  1    1 = aligned to frame boundaries (FSM state LOCKED)
//   sync_err    out  1    one-cycle strobe: framing violation detected
//   err_cnt     out  8    saturating framing-error count; this port exists
//                         only when TDM_ERR_CNT_EN is defined
//
// Optional feature: define TDM_ERR_CNT_EN to add the err_cnt port and its
// counter. The default build leaves it out and is otherwise identical.
//
// Handshake: the input has no back-pressure. A beat is any cycle with
// din_valid=1, and it is consumed in that cycle. dout_valid is a plain strobe
// with no ready. dout keeps its value until the next complete frame
// overwrites it.
// -----------------------------------------------------------------------------
module tdm_demux_1xn #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   din,
  input  logic           din_valid,
  input  logic           frame_sync,
  output logic [N*W-1:0] dout,
  output logic           dout_valid,
  output logic           locked,
  output logic           sync_err
`ifdef TDM_ERR_CNT_EN
  ,
  output logic [7:0]     err_cnt
`endif
);

  // Width of the slot counter. N=2 still needs one bit.
  localparam int SW = (N > 2) ? $clog2(N) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(N - 1);
  localparam logic [SW-1:0] SLOT_ONE  = SW'(1);

  typedef enum logic [0:0] {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t              state;
  logic [SW-1:0]       slot;
  // Holds samples for slots 0..N-2. The last sample goes straight from din
  // into dout, so there is no staging entry for it.
  logic [(N-1)*W-1:0]  staging;

  // A framing violation can only be seen while locked:
  //  - a sync beat at any position other than slot 0 (early sync), or
  //  - a beat without sync where slot 0 is expected (missing sync).
  logic err_event;

  always_comb begin
    err_event = 1'b0;
    if (din_valid && (state == ST_LOCKED)) begin
      if (frame_sync)
        err_event = (slot != '0);
      else
        err_event = (slot == '0);
    end
  end

  // The FSM state is the locked flag. Both are registered.
  assign locked = (state == ST_LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_SEARCH;
      slot       <= '0;
      staging    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      // Strobes are low unless this cycle's beat raises them.
      dout_valid <= 1'b0;
      sync_err   <= err_event;
      if (din_valid) begin
        case (state)
          ST_SEARCH: begin
            // Beats without sync are dropped until a slot 0 shows up.
            if (frame_sync) begin
              staging[W-1:0] <= din;
              slot           <= SLOT_ONE;
              state          <= ST_LOCKED;
            end
          end
          ST_LOCKED: begin
            if (frame_sync) begin
              // Normal slot 0, or an early sync that restarts the frame.
              // Any partial frame is abandoned, and dout is left alone.
              staging[W-1:0] <= din;
              slot           <= SLOT_ONE;
            end else if (slot == '0) begin
              // Missing sync: drop the beat and hunt for alignment again.
              state <= ST_SEARCH;
            end else if (slot == SLOT_LAST) begin
              // Last beat: publish the whole frame at once.
              dout       <= {din, staging};
              dout_valid <= 1'b1;
              slot       <= '0;
            end else begin
              staging[slot*W +: W] <= din;
              slot                 <= slot + SLOT_ONE;
            end
          end
          default: begin
            state <= ST_SEARCH;
            slot  <= '0;
          end
        endcase
      end
    end
  end

`ifdef TDM_ERR_CNT_EN
  // Counts the same events that raise sync_err. It holds at 255 once it
  // gets there and is cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst)
      err_cnt <= '0;
    else if (err_event && (err_cnt != 8'hFF))
      err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_tdm_demux_1xn.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux_1xn
//
// Bench for tdm_demux_1xn with N=4, W=8. The reference model describes a
// frame as a queue of samples collected since the last sync. It works from
// the frame rules only and does not follow the RTL's slot counter.
// -----------------------------------------------------------------------------
module tb_tdm_demux_1xn;

  localparam int N = 4;
  localparam int W = 8;

  // ---------------------------------------------------------------- clock/reset
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   din = '0;
  logic           din_valid = 1'b0;
  logic           frame_sync = 1'b0;
  logic [N*W-1:0] dout;
  logic           dout_valid;
  logic           locked;
  logic           sync_err;
`ifdef TDM_ERR_CNT_EN
  logic [7:0]     err_cnt;
`endif

  always #5 clk = ~clk;

  tdm_demux_1xn #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .locked     (locked),
    .sync_err   (sync_err)
`ifdef TDM_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  // ---------------------------------------------------------------- scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [N*W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  logic           m_locked = 1'b0;
  logic [W-1:0]   m_frame[$];
  logic [N*W-1:0] m_dout = '0;
  logic           m_valid = 1'b0;
  logic           m_serr = 1'b0;
  int             m_cnt = 0;

  task automatic model_step(input logic r, input logic v, input logic s, input logic [W-1:0] d);
    m_valid = 1'b0;
    m_serr  = 1'b0;
    if (r) begin
      m_locked = 1'b0;
      m_frame.delete();
      m_dout = '0;
      m_cnt  = 0;
    end else if (v) begin
      if (!m_locked) begin
        if (s) begin
          m_frame.delete();
          m_frame.push_back(d);
          m_locked = 1'b1;
        end
      end else if (s) begin
        // A sync beat while samples are pending means the frame was cut short.
        if (m_frame.size() != 0) m_serr = 1'b1;
        m_frame.delete();
        m_frame.push_back(d);
      end else if (m_frame.size() == 0) begin
        m_serr   = 1'b1;
        m_locked = 1'b0;
      end else begin
        m_frame.push_back(d);
        if (m_frame.size() == N) begin
          for (int k = 0; k < N; k++) m_dout[k*W +: W] = m_frame[k];
          m_valid = 1'b1;
          exp_q.push_back(m_dout);
          m_frame.delete();
        end
      end
      if (m_serr && m_cnt < 255) m_cnt++;
    end
  endtask

  // ---------------------------------------------------------------- driver
  // Drives one cycle, lets the clock edge happen, updates the model, then
  // samples the DUT 1 time unit after the edge.
  task automatic cycle(input logic r, input logic v, input logic s, input logic [W-1:0] d);
    rst = r; din_valid = v; frame_sync = s; din = d;
    @(posedge clk);
    model_step(r, v, s, d);
    #1;
    check("dout", dout, m_dout);
    check("dout_valid", dout_valid, m_valid);
    check("locked", locked, m_locked);
    check("sync_err", sync_err, m_serr);
`ifdef TDM_ERR_CNT_EN
    check("err_cnt", err_cnt, m_cnt);
`endif
    if (dout_valid === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_frame", dout, '1);
      else check("frame", dout, exp_q.pop_front());
    end
  endtask

  task automatic beat(input logic s, input logic [W-1:0] d);
    cycle(1'b0, 1'b1, s, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, $urandom_range(0, 1), W'($urandom));
  endtask

  task automatic good_frame(input logic [W-1:0] b0, input logic [W-1:0] b1,
                            input logic [W-1:0] b2, input logic [W-1:0] b3,
                            input int max_gap);
    beat(1'b1, b0); idle($urandom_range(0, max_gap));
    beat(1'b0, b1); idle($urandom_range(0, max_gap));
    beat(1'b0, b2); idle($urandom_range(0, max_gap));
    beat(1'b0, b3);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    // 1. Reset held for 3 cycles with random inputs.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, $urandom_range(0, 1), $urandom_range(0, 1), W'($urandom));
    check("reset_dout", dout, '0);

    // 2. Back-to-back frame.
    good_frame(8'h11, 8'h22, 8'h33, 8'h44, 0);
    check("frame_44332211", dout, 32'h44332211);
    idle(1);

    // 3. The same frame with gaps of 1-3 cycles.
    rst = 1'b0; din_valid = 1'b0;
    beat(1'b1, 8'h11); idle($urandom_range(1, 3));
    beat(1'b0, 8'h22); idle($urandom_range(1, 3));
    beat(1'b0, 8'h33); idle($urandom_range(1, 3));
    beat(1'b0, 8'h44);
    check("gap_frame", dout, 32'h44332211);
    idle(2);

    // 4. Early sync: fragment 01,02, then a fresh frame.
    beat(1'b1, 8'h01); beat(1'b0, 8'h02);
    beat(1'b1, 8'hAA);
    check("early_sync_err", sync_err, 1'b1);
    beat(1'b0, 8'hBB); beat(1'b0, 8'hCC); beat(1'b0, 8'hDD);
    check("early_frame", dout, 32'hDDCCBBAA);

    // 5. Missing sync after a good frame.
    good_frame(8'h12, 8'h34, 8'h56, 8'h78, 1);
    beat(1'b0, 8'h55);
    check("missing_sync_err", sync_err, 1'b1);
    check("missing_sync_unlock", locked, 1'b0);
    beat(1'b0, 8'h66); beat(1'b0, 8'h77); beat(1'b0, 8'h88);
    check("missing_sync_hold", dout, 32'h78563412);
    good_frame(8'hA1, 8'hB2, 8'hC3, 8'hD4, 0);
    check("relock", locked, 1'b1);

    // 6. Reset in the middle of a frame.
    beat(1'b1, 8'h99); beat(1'b0, 8'h98);
    cycle(1'b1, 1'b1, 1'b0, 8'h97);
    good_frame(8'hEE, 8'hEF, 8'hF0, 8'hF1, 2);
    check("post_reset_frame", dout, 32'hF1F0EFEE);

    // Randomized traffic, mostly well-formed, with occasional faults.
    for (int f = 0; f < 400; f++) begin
      int kind = $urandom_range(0, 19);
      if (kind == 0) begin
        cycle(1'b1, $urandom_range(0, 1), $urandom_range(0, 1), W'($urandom));
      end else if (kind < 4) begin
        for (int i = 0; i < 4; i++) begin
          if ($urandom_range(0, 2) == 0) idle(1);
          beat($urandom_range(0, 3) == 0, W'($urandom));
        end
      end else begin
        good_frame(W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                   ($urandom_range(0, 1) == 0) ? 0 : 2);
      end
    end

`ifdef TDM_ERR_CNT_EN
    // Saturation: each repeated sync beat is an early-sync error.
    beat(1'b1, 8'h00);
    for (int i = 0; i < 300; i++) beat(1'b1, W'($urandom));
    check("err_cnt_sat", err_cnt, 8'hFF);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    check("err_cnt_clear", err_cnt, 8'h00);
`endif

    idle(3);
    check("exp_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
